// File: rtl/exception_status_unit.sv
// exception_status_unit: decodes arithmetic exception codes leaving writeback,
// buffers {code, pc} in a small FIFO drained over valid/ready, and keeps
// sticky per-cause, lost-event and illegal-code flags.
// Optional build macro: EXC_STATUS_COUNTERS_EN adds five saturating per-cause
// counters readable through count_sel/count_out.
module exception_status_unit #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              exc_valid,
   input  logic [31:0]       exc_code,
   input  logic [31:0]       exc_pc,
   input  logic              clear,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [2:0]        rd_code,
   output logic [4:0]        rd_cause,
   output logic [31:0]       rd_pc,
   output logic [4:0]        sticky_cause,
   output logic              lost,
   output logic              illegal,
   input  logic [2:0]        count_sel,
   output logic [CNT_W-1:0]  count_out
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = AW + 1;

   // One-hot cause for a 1..5 code; anything else decodes to no cause.
   function automatic logic [4:0] decodeCause(input logic [2:0] code);
      logic [4:0] cause;
      cause = '0;
      case (code)
         3'd1:    cause = 5'b00001;
         3'd2:    cause = 5'b00010;
         3'd3:    cause = 5'b00100;
         3'd4:    cause = 5'b01000;
         3'd5:    cause = 5'b10000;
         default: cause = '0;
      endcase
      return cause;
   endfunction

   logic [2:0]    memCode [DEPTH];
   logic [31:0]   memPc   [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [OW-1:0] occupancy;

   logic          isLegal;
   logic          isIllegal;
   logic          isFull;
   logic          doPop;
   logic          doPush;
   logic          doDrop;
   logic [4:0]    newCause;

   // Event classification and FIFO handshake decisions.
   always_comb begin
      isLegal   = exc_valid && (exc_code >= 32'd1) && (exc_code <= 32'd5);
      isIllegal = exc_valid && (exc_code > 32'd5);
      isFull    = (occupancy == OW'(DEPTH));
      doPop     = rd_valid && rd_ready;
      doPush    = isLegal && (!isFull || doPop);
      doDrop    = isLegal && isFull && !doPop;
      newCause  = isLegal ? decodeCause(exc_code[2:0]) : 5'b00000;
   end

   // Head entry is read straight from registered storage.
   assign rd_valid = (occupancy != '0);
   assign rd_code  = memCode[rdPtr];
   assign rd_pc    = memPc[rdPtr];
   assign rd_cause = rd_valid ? decodeCause(memCode[rdPtr]) : 5'b00000;

   // FIFO storage, pointers and occupancy; reset discards queued entries.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            memCode[i] <= '0;
            memPc[i]   <= '0;
         end
      end else begin
         if (doPush) begin
            memCode[wrPtr] <= exc_code[2:0];
            memPc[wrPtr]   <= exc_pc;
            wrPtr          <= wrPtr + AW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   occupancy <= occupancy + OW'(1);
            2'b01:   occupancy <= occupancy - OW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Sticky flags: clear takes effect first, then same-cycle events set bits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sticky_cause <= '0;
         lost         <= 1'b0;
         illegal      <= 1'b0;
      end else begin
         sticky_cause <= (clear ? 5'b00000 : sticky_cause) | newCause;
         lost         <= (clear ? 1'b0 : lost) | doDrop;
         illegal      <= (clear ? 1'b0 : illegal) | isIllegal;
      end
   end

`ifdef EXC_STATUS_COUNTERS_EN
   logic [CNT_W-1:0] causeCnt [5];

   // Saturating per-cause counters; dropped events still count.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 5; i++) begin
            causeCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (newCause[i]) begin
               if (clear) begin
                  causeCnt[i] <= CNT_W'(1);
               end else if (causeCnt[i] != '1) begin
                  causeCnt[i] <= causeCnt[i] + CNT_W'(1);
               end
            end else if (clear) begin
               causeCnt[i] <= '0;
            end
         end
      end
   end

   // Counter read mux; out-of-range selects read as zero.
   always_comb begin
      count_out = '0;
      case (count_sel)
         3'd0:    count_out = causeCnt[0];
         3'd1:    count_out = causeCnt[1];
         3'd2:    count_out = causeCnt[2];
         3'd3:    count_out = causeCnt[3];
         3'd4:    count_out = causeCnt[4];
         default: count_out = '0;
      endcase
   end
`else
   logic unusedSel;
   assign unusedSel = ^count_sel;
   assign count_out = '0;
`endif

endmodule

// File: tb/tb_exception_status_unit.sv
// Bench for exception_status_unit: table-driven vectors with a FIFO scoreboard
// plus hand sequences for reset behaviour.
module tb_exception_status_unit;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              exc_valid;
   logic [31:0]       exc_code;
   logic [31:0]       exc_pc;
   logic              clear;
   logic              rd_ready;
   logic              rd_valid;
   logic [2:0]        rd_code;
   logic [4:0]        rd_cause;
   logic [31:0]       rd_pc;
   logic [4:0]        sticky_cause;
   logic              lost;
   logic              illegal;
   logic [2:0]        count_sel;
   logic [CNT_W-1:0]  count_out;

   exception_status_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
      .exc_pc(exc_pc), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
      .rd_code(rd_code), .rd_cause(rd_cause), .rd_pc(rd_pc),
      .sticky_cause(sticky_cause), .lost(lost), .illegal(illegal),
      .count_sel(count_sel), .count_out(count_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [31:0] code;
      logic [31:0] pc;
      logic        rdy;
      logic        clr;
      logic [2:0]  sel;
      logic [4:0]  expSticky;
      logic        expLost;
      logic        expIll;
   } vec_t;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] pc;
   } ent_t;

   ent_t sb[$];
   vec_t tv[$];
   int   total = 0;
   int   bad   = 0;

`ifdef EXC_STATUS_COUNTERS_EN
   logic [CNT_W-1:0] mCnt [5];
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] oneHot(input logic [2:0] c);
      return 5'(1) << (c - 3'd1);
   endfunction

   function automatic logic [31:0] expCount(input logic [2:0] sel);
`ifdef EXC_STATUS_COUNTERS_EN
      if (sel < 3'd5) return 32'(mCnt[sel]);
      return 32'd0;
`else
      return 32'(sel) & 32'd0;
`endif
   endfunction

   function automatic vec_t mk(input logic v, input logic [31:0] code, input logic [31:0] pc,
                               input logic rdy, input logic clr, input logic [2:0] sel,
                               input logic [4:0] st, input logic l, input logic il);
      vec_t t;
      t = '{v, code, pc, rdy, clr, sel, st, l, il};
      return t;
   endfunction

   task automatic checkHead(input string tag);
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         chk({tag, " rd_code"}, 32'(rd_code), 32'(sb[0].code));
         chk({tag, " rd_pc"}, rd_pc, sb[0].pc);
         chk({tag, " rd_cause"}, 32'(rd_cause), 32'(oneHot(sb[0].code)));
      end else begin
         chk({tag, " rd_cause"}, 32'(rd_cause), 32'd0);
      end
   endtask

   // Drive one cycle of stimulus at a falling edge, update the model, check after the next rising edge.
   task automatic applyVec(input vec_t t, input string tag);
      bit   pop;
      bit   legal;
      bit   push;
      ent_t e;
      pop   = (sb.size() != 0) && t.rdy;
      legal = t.v && (t.code >= 32'd1) && (t.code <= 32'd5);
      push  = legal && ((sb.size() < int'(DEPTH)) || pop);
      exc_valid = t.v;
      exc_code  = t.code;
      exc_pc    = t.pc;
      rd_ready  = t.rdy;
      clear     = t.clr;
      count_sel = t.sel;
      if (pop) e = sb.pop_front();
      if (push) begin
         e.code = t.code[2:0];
         e.pc   = t.pc;
         sb.push_back(e);
      end
`ifdef EXC_STATUS_COUNTERS_EN
      if (t.clr) for (int i = 0; i < 5; i++) mCnt[i] = '0;
      if (legal && mCnt[int'(t.code) - 1] != '1)
         mCnt[int'(t.code) - 1] = mCnt[int'(t.code) - 1] + CNT_W'(1);
`endif
      @(negedge clock);
      chk({tag, " sticky"}, 32'(sticky_cause), 32'(t.expSticky));
      chk({tag, " lost"}, 32'(lost), 32'(t.expLost));
      chk({tag, " illegal"}, 32'(illegal), 32'(t.expIll));
      chk({tag, " count_out"}, 32'(count_out), expCount(t.sel));
      checkHead(tag);
   endtask

   // Hold reset low across one rising edge and check every output is cleared.
   task automatic doReset(input string tag);
      reset     = 1'b0;
      exc_valid = 1'b0;
      exc_code  = '0;
      exc_pc    = '0;
      clear     = 1'b0;
      rd_ready  = 1'b0;
      count_sel = 3'd3;
      @(negedge clock);
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, " rd_code"}, 32'(rd_code), 32'd0);
      chk({tag, " rd_cause"}, 32'(rd_cause), 32'd0);
      chk({tag, " rd_pc"}, rd_pc, 32'd0);
      chk({tag, " sticky"}, 32'(sticky_cause), 32'd0);
      chk({tag, " lost"}, 32'(lost), 32'd0);
      chk({tag, " illegal"}, 32'(illegal), 32'd0);
      chk({tag, " count_out"}, 32'(count_out), 32'd0);
      reset = 1'b1;
      sb.delete();
`ifdef EXC_STATUS_COUNTERS_EN
      for (int i = 0; i < 5; i++) mCnt[i] = '0;
`endif
   endtask

   initial begin
      // single event, hold, pop
      tv.push_back(mk(1, 3, 32'h40, 0, 0, 2, 5'b00100, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 2, 5'b00100, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 2, 5'b00100, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 2, 5'b00100, 0, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 2, 5'b00100, 0, 0));
      // overflow: 1,2,4,5,1 with no reads
      tv.push_back(mk(0, 0, 0, 0, 1, 0, 5'b00000, 0, 0));
      tv.push_back(mk(1, 1, 32'h100, 0, 0, 0, 5'b00001, 0, 0));
      tv.push_back(mk(1, 2, 32'h104, 0, 0, 1, 5'b00011, 0, 0));
      tv.push_back(mk(1, 4, 32'h108, 0, 0, 3, 5'b01011, 0, 0));
      tv.push_back(mk(1, 5, 32'h10c, 0, 0, 4, 5'b11011, 0, 0));
      tv.push_back(mk(1, 1, 32'h110, 0, 0, 0, 5'b11011, 1, 0));
      for (int i = 0; i < 4; i++) tv.push_back(mk(0, 0, 0, 1, 0, 0, 5'b11011, 1, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 5'b11011, 1, 0));
      // full FIFO with simultaneous push and pop, then a genuine drop
      tv.push_back(mk(1, 1, 32'h200, 0, 1, 0, 5'b00001, 0, 0));
      tv.push_back(mk(1, 2, 32'h204, 0, 0, 1, 5'b00011, 0, 0));
      tv.push_back(mk(1, 3, 32'h208, 0, 0, 2, 5'b00111, 0, 0));
      tv.push_back(mk(1, 4, 32'h20c, 0, 0, 3, 5'b01111, 0, 0));
      tv.push_back(mk(1, 2, 32'h210, 1, 0, 1, 5'b01111, 0, 0));
      tv.push_back(mk(1, 5, 32'h214, 0, 0, 4, 5'b11111, 1, 0));
      for (int i = 0; i < 4; i++) tv.push_back(mk(0, 0, 0, 1, 0, 1, 5'b11111, 1, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 1, 5'b11111, 1, 0));
      // illegal codes and code 0
      tv.push_back(mk(0, 0, 0, 0, 1, 0, 5'b00000, 0, 0));
      tv.push_back(mk(1, 6, 32'h300, 0, 0, 0, 5'b00000, 0, 1));
      tv.push_back(mk(1, 32'h101, 32'h304, 0, 0, 0, 5'b00000, 0, 1));
      tv.push_back(mk(1, 0, 32'h308, 0, 0, 0, 5'b00000, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 1, 0, 5'b00000, 0, 0));
      // clear together with a new event
      tv.push_back(mk(1, 1, 32'h400, 1, 0, 0, 5'b00001, 0, 0));
      tv.push_back(mk(1, 1, 32'h404, 1, 0, 0, 5'b00001, 0, 0));
      tv.push_back(mk(1, 5, 32'h408, 1, 1, 4, 5'b10000, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 0, 5'b10000, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 4, 5'b10000, 0, 0));
      // counter saturation under sustained push/pop
      for (int i = 0; i < 6; i++) tv.push_back(mk(1, 4, 32'h500 + 32'(i * 4), 1, 0, 3, 5'b11000, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 5, 5'b11000, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 7, 5'b11000, 0, 0));
      tv.push_back(mk(0, 0, 0, 1, 0, 3, 5'b11000, 0, 0));

      doReset("reset");
      foreach (tv[i]) applyVec(tv[i], $sformatf("vec%0d", i));

      // reset while entries are queued discards them
      applyVec(mk(1, 1, 32'h600, 0, 0, 0, 5'b11001, 0, 0), "pre-reset0");
      applyVec(mk(1, 2, 32'h604, 0, 0, 1, 5'b11011, 0, 0), "pre-reset1");
      doReset("mid-reset");
      applyVec(mk(0, 0, 0, 1, 0, 0, 5'b00000, 0, 0), "post-reset-idle");
      applyVec(mk(1, 3, 32'h700, 0, 0, 2, 5'b00100, 0, 0), "post-reset-ev");
      applyVec(mk(0, 0, 0, 1, 0, 2, 5'b00100, 0, 0), "post-reset-pop");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
